// File: rtl/rx_clk_speed_detect.sv
// Classifies the RX clock as 1000M/100M/10M/none by counting toggle edges
// per fixed hclk_i window and adopting a class only after two matching windows.
module rx_clk_speed_detect #(
    parameter int WIN_LOG2 = 12,
    parameter int TH_1000  = 192,
    parameter int TH_100   = 32,
    parameter int TH_10    = 3
) (
    input  logic                hclk_i,
    input  logic                hrst_i,
    input  logic                rx_tgl_i,
    output logic [1:0]          speed_o,
    output logic                clk_ok_o,
    output logic                speed_chg_o,
    output logic [WIN_LOG2:0]   edge_cnt_o
);

    // state    | meaning
    // ST_MEAS  | counting edges inside the current window
    // ST_EVAL  | one cycle after window close: classify and confirm
    typedef enum logic [0:0] {ST_MEAS, ST_EVAL} state_t;

    // Class codes for valid speeds equal the speed_o encoding.
    typedef enum logic [1:0] {
        CLS_10   = 2'b00,
        CLS_100  = 2'b01,
        CLS_1000 = 2'b10,
        CLS_NONE = 2'b11
    } cls_t;

    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] C_TH_1000 = CW'(TH_1000);
    localparam logic [CW-1:0] C_TH_100  = CW'(TH_100);
    localparam logic [CW-1:0] C_TH_10   = CW'(TH_10);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [2:0]          r_vld;
    logic [WIN_LOG2-1:0] r_win;
    logic [CW-1:0]       r_edge_cnt;
    logic [CW-1:0]       r_edge_last;
    state_t              r_state;
    cls_t                r_cand;
    logic                r_match;
    logic [1:0]          r_speed;
    logic                r_clk_ok;
    logic                r_chg;

    logic                w_edge;
    logic                w_term;
    logic [CW-1:0]       w_cnt_next;
    cls_t                w_cls;
    logic [1:0]          w_cls_code;

    always_comb begin
        // r_vld keeps the edge detector quiet until sync3 holds a real sample.
        w_edge = r_vld[2] & (r_sync2 ^ r_sync3);
        w_term = &r_win;
        w_cnt_next = r_edge_cnt;
        if (w_edge && !(&r_edge_cnt)) begin
            w_cnt_next = r_edge_cnt + 1'b1;
        end
    end

    always_comb begin
        w_cls = CLS_NONE;
        if (r_edge_last >= C_TH_1000) begin
            w_cls = CLS_1000;
        end else if (r_edge_last >= C_TH_100) begin
            w_cls = CLS_100;
        end else if (r_edge_last >= C_TH_10) begin
            w_cls = CLS_10;
        end
        w_cls_code = w_cls;
    end

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_vld       <= 3'b000;
            r_win       <= '0;
            r_edge_cnt  <= '0;
            r_edge_last <= '0;
            r_state     <= ST_MEAS;
            r_cand      <= CLS_NONE;
            r_match     <= 1'b0;
            r_speed     <= 2'b00;
            r_clk_ok    <= 1'b0;
            r_chg       <= 1'b0;
        end else begin
            r_sync1 <= rx_tgl_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_vld   <= {r_vld[1:0], 1'b1};
            r_win   <= r_win + 1'b1;
            r_chg   <= 1'b0;

            if (w_term) begin
                r_edge_last <= w_cnt_next;
                r_edge_cnt  <= '0;
            end else begin
                r_edge_cnt  <= w_cnt_next;
            end

            case (r_state)
                ST_MEAS: begin
                    if (w_term) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_state <= ST_MEAS;
                    if (w_cls == r_cand) begin
                        // A set match flag means outputs already carry this class.
                        r_match <= 1'b1;
                        if (w_cls == CLS_NONE) begin
                            r_clk_ok <= 1'b0;
                            r_chg    <= !r_match && r_clk_ok;
                        end else begin
                            r_speed  <= w_cls_code;
                            r_clk_ok <= 1'b1;
                            r_chg    <= !r_match && ((r_speed != w_cls_code) || !r_clk_ok);
                        end
                    end else begin
                        r_cand  <= w_cls;
                        r_match <= 1'b0;
                    end
                end
                default: r_state <= ST_MEAS;
            endcase
        end
    end

    assign speed_o     = r_speed;
    assign clk_ok_o    = r_clk_ok;
    assign speed_chg_o = r_chg;
    assign edge_cnt_o  = r_edge_last;

endmodule

// File: tb/tb_rx_clk_speed_detect.sv
// Self-checking bench: random-phase toggle streams checked against a
// window-level model of edge counting and two-window class confirmation.
module tb_rx_clk_speed_detect;

    logic        hclk_i = 1'b0;
    logic        hrst_i = 1'b1;
    logic        rx_tgl_i = 1'b0;
    logic [1:0]  speed_o;
    logic        clk_ok_o;
    logic        speed_chg_o;
    logic [12:0] edge_cnt_o;

    rx_clk_speed_detect dut (
        .hclk_i      (hclk_i),
        .hrst_i      (hrst_i),
        .rx_tgl_i    (rx_tgl_i),
        .speed_o     (speed_o),
        .clk_ok_o    (clk_ok_o),
        .speed_chg_o (speed_chg_o),
        .edge_cnt_o  (edge_cnt_o)
    );

    always #4 hclk_i = ~hclk_i;

    int errors = 0;
    int checks = 0;

    // Model state: n = index of the next hclk_i posedge since reset release.
    int   n;
    logic v;
    logic prev;
    int   cnt [0:63];
    int   half;
    int   ph;
    int   cand;       // 0 none, 1 10M, 2 100M, 3 1000M
    int   exp_speed;
    int   exp_ok;
    int   exp_chg;
    int   obs_pulses;
    int   exp_pulses;

    function automatic int classify(input int c);
        if (c >= 192) return 3;
        if (c >= 32)  return 2;
        if (c >= 3)   return 1;
        return 0;
    endfunction

    task automatic set_mode(input int h);
        half = h;
        if (h > 1) ph = $urandom_range(h - 1, 1);
        else        ph = 0;
    endtask

    task automatic drive_cycle();
        int idx;
        if (half > 0) begin
            if (ph == 0) begin
                v  = ~v;
                ph = half - 1;
            end else begin
                ph = ph - 1;
            end
        end
        // Sample n is compared with sample n-1 and counted at posedge n+2.
        idx = (n + 2) >> 12;
        if (n >= 1 && v != prev && idx < 64) cnt[idx] = cnt[idx] + 1;
        prev     = v;
        rx_tgl_i = v;
        n        = n + 1;
    endtask

    task automatic observe();
        int p;
        int k;
        int cls;
        int ns;
        int nok;
        p = n - 1;
        if (speed_chg_o === 1'b1) obs_pulses = obs_pulses + 1;
        if (p % 4096 == 4095) begin
            k = p / 4096;
            checks = checks + 1;
            if (edge_cnt_o !== 13'(cnt[k])) begin
                errors = errors + 1;
                $display("FAIL edge_cnt window=%0d actual=%0d expected=%0d", k, edge_cnt_o, cnt[k]);
            end
            cls = classify(cnt[k]);
            exp_chg = 0;
            if (cls == cand) begin
                ns  = (cls == 0) ? exp_speed : cls - 1;
                nok = (cls == 0) ? 0 : 1;
                if (ns != exp_speed || nok != exp_ok) begin
                    exp_chg    = 1;
                    exp_pulses = exp_pulses + 1;
                end
                exp_speed = ns;
                exp_ok    = nok;
            end else begin
                cand = cls;
            end
        end
        if (p % 4096 == 0 && p >= 4096) begin
            checks = checks + 3;
            if (speed_o !== 2'(exp_speed)) begin
                errors = errors + 1;
                $display("FAIL speed_o at=%0d actual=%0d expected=%0d", p, speed_o, exp_speed);
            end
            if (clk_ok_o !== 1'(exp_ok)) begin
                errors = errors + 1;
                $display("FAIL clk_ok_o at=%0d actual=%0d expected=%0d", p, clk_ok_o, exp_ok);
            end
            if (speed_chg_o !== 1'(exp_chg)) begin
                errors = errors + 1;
                $display("FAIL speed_chg_o at=%0d actual=%0d expected=%0d", p, speed_chg_o, exp_chg);
            end
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive_cycle();
            @(posedge hclk_i);
            @(negedge hclk_i);
            observe();
        end
    endtask

    task automatic do_reset(input logic lvl);
        @(negedge hclk_i);
        hrst_i   = 1'b1;
        rx_tgl_i = lvl;
        repeat (4) @(negedge hclk_i);
        checks = checks + 2;
        if (speed_o !== 2'b00 || clk_ok_o !== 1'b0 || speed_chg_o !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs actual=%0d/%0d/%0d expected=0/0/0", speed_o, clk_ok_o, speed_chg_o);
        end
        if (edge_cnt_o !== 13'd0) begin
            errors = errors + 1;
            $display("FAIL reset_edge_cnt actual=%0d expected=0", edge_cnt_o);
        end
        hrst_i     = 1'b0;
        n          = 0;
        v          = lvl;
        prev       = lvl;
        half       = 0;
        ph         = 0;
        cand       = 0;
        exp_speed  = 0;
        exp_ok     = 0;
        exp_chg    = 0;
        obs_pulses = 0;
        exp_pulses = 0;
        foreach (cnt[i]) cnt[i] = 0;
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_pulses(input string name);
        checks = checks + 1;
        if (obs_pulses != exp_pulses) begin
            errors = errors + 1;
            $display("FAIL %s pulses actual=%0d expected=%0d", name, obs_pulses, exp_pulses);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        run(20);
        check_int("post_reset_speed", int'(speed_o), 0);
        check_int("post_reset_ok", int'(clk_ok_o), 0);
    endtask

    task automatic test_speed_1000();
        do_reset(1'b0);
        set_mode(16);
        run(8200);
        check_int("1000_edge_cnt", int'(edge_cnt_o), 256);
        check_int("1000_speed", int'(speed_o), 2);
        check_int("1000_ok", int'(clk_ok_o), 1);
        check_int("1000_one_pulse", obs_pulses, 1);
        check_pulses("1000");
    endtask

    task automatic test_freeze();
        int base;
        base = obs_pulses;
        set_mode(0);
        run(3 * 4096);
        check_int("freeze_edge_cnt", int'(edge_cnt_o), 0);
        check_int("freeze_ok", int'(clk_ok_o), 0);
        check_int("freeze_speed_hold", int'(speed_o), 2);
        check_int("freeze_one_pulse", obs_pulses - base, 1);
        check_pulses("freeze");
    endtask

    task automatic test_speed_100();
        int e;
        do_reset(1'b0);
        set_mode(80);
        run(8200);
        e = int'(edge_cnt_o);
        check_int("100_edge_range", int'(e == 51 || e == 52), 1);
        check_int("100_speed", int'(speed_o), 1);
        check_int("100_ok", int'(clk_ok_o), 1);
        check_pulses("100");
    endtask

    task automatic test_speed_10();
        int e;
        do_reset(1'b0);
        set_mode(800);
        run(8200);
        e = int'(edge_cnt_o);
        check_int("10_edge_range", int'(e == 5 || e == 6), 1);
        check_int("10_speed", int'(speed_o), 0);
        check_int("10_ok", int'(clk_ok_o), 1);
        check_int("10_one_pulse", obs_pulses, 1);
        check_pulses("10");
    endtask

    task automatic test_alternate();
        do_reset(1'b0);
        set_mode(16);
        run(4096);
        set_mode(80);
        run(4096);
        set_mode(16);
        run(4100);
        check_int("alt_no_pulse", obs_pulses, 0);
        check_int("alt_ok", int'(clk_ok_o), 0);
        check_pulses("alt");
    endtask

    task automatic test_reset_midwindow();
        set_mode(16);
        run(1500);
        do_reset(1'b1);
        set_mode(16);
        run(8200);
        check_int("midrst_edge_cnt", int'(edge_cnt_o), 256);
        check_int("midrst_speed", int'(speed_o), 2);
        check_pulses("midrst");
    endtask

    task automatic test_random();
        int mode_tab [0:3];
        mode_tab[0] = 16;
        mode_tab[1] = 80;
        mode_tab[2] = 800;
        mode_tab[3] = 0;
        do_reset(1'($urandom_range(1, 0)));
        for (int s = 0; s < 8; s++) begin
            set_mode(mode_tab[$urandom_range(3, 0)]);
            run(1024);
        end
        run(4);
        check_pulses("random");
    endtask

    initial begin
        test_reset();
        test_speed_1000();
        test_freeze();
        test_speed_100();
        test_speed_10();
        test_alternate();
        test_reset_midwindow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
